// File: rtl/add16_arbiter.sv
// add16_arbiter: N_REQ requesters share a single 16-bit ripple adder (Add16) through an IDLE/ADD/RESP FSM.
// Latency: gnt after the capture edge, out one edge later, ack pulse two edges later; one operation per 3 cycles.
// Backpressure: none; requests seen outside IDLE are dropped. `ADD16_ARB_RR_EN selects round-robin, otherwise fixed priority.
module add16_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [16*N_REQ-1:0] a_in,
  input  logic [16*N_REQ-1:0] b_in,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    ack,
  output logic [15:0]         out,
  output logic                busy
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [15:0]      op_a_q, op_a_d;
  logic [15:0]      op_b_q, op_b_d;
  logic [15:0]      out_q, out_d;
  logic [15:0]      sum;
  logic             win_vld;
  logic [PW-1:0]    win_idx;

`ifdef ADD16_ARB_RR_EN
  logic [PW-1:0] ptr_q, ptr_d;

  // Two passes emulate a circular search starting at ptr_q without a variable rotate.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_vld && req[i] && (PW'(i) >= ptr_q)) begin
        win_vld = 1'b1;
        win_idx = PW'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_vld && req[i]) begin
        win_vld = 1'b1;
        win_idx = PW'(i);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && win_vld) begin
      ptr_d = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_vld = 1'b1;
        win_idx = PW'(i);
      end
    end
  end
`endif

  Add16 u_add16 (
    .a (op_a_q),
    .b (op_b_q),
    .s (sum)
  );

  // gnt is held through the ack cycle and only re-evaluated at the next IDLE edge.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (win_vld) begin
          for (int i = 0; i < N_REQ; i++) begin
            if (PW'(i) == win_idx) begin
              gnt_d[i] = 1'b1;
              op_a_d   = a_in[16*i +: 16];
              op_b_d   = b_in[16*i +: 16];
            end
          end
          state_d = ADD;
        end
      end
      ADD: begin
        out_d   = sum;
        state_d = RESP;
      end
      RESP: begin
        ack_d   = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      out_q   <= out_d;
    end
  end

  assign gnt  = gnt_q;
  assign ack  = ack_q;
  assign out  = out_q;
  // The ack cycle still belongs to the operation, so busy covers it too.
  assign busy = (state_q != IDLE) | (|ack_q);

endmodule

// Add16: 16-bit ripple-carry adder, carry out dropped (modulo 2^16).
module Add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] s
);
  logic carry;

  always_comb begin
    carry = 1'b0;
    s     = '0;
    for (int i = 0; i < 16; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

endmodule

// File: doc/add16_arbiter.md
ADD16_ARBITER -- requirements
Module: add16_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the adder; legal 2..8.
REQ-002 Port clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port req  input  N_REQ  per-requester operation request, level.
REQ-005 Port a_in  input  16*N_REQ  flattened operand A, requester i at bits [16i+15:16i].
REQ-006 Port b_in  input  16*N_REQ  flattened operand B, same packing as a_in.
REQ-007 Port gnt  output  N_REQ  one-hot grant, registered; high from capture through ack.
REQ-008 Port ack  output  N_REQ  one-hot one-cycle completion pulse.
REQ-009 Port out  output  16  sum of granted operands; valid in the ack cycle and held until the next ack.
REQ-010 Port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-011 The block SHALL contain exactly one instance of the team's 16-bit ripple adder (Add16) and route all additions through it.
REQ-012 The FSM SHALL have states IDLE, ADD and RESP; encoding is free.
REQ-013 IDLE: if any req bit is high, select one winner (REQ-018), latch its a/b into internal operand registers, set gnt[winner], go to ADD; otherwise stay in IDLE with gnt=0.
REQ-014 ADD: register the adder output into out; go to RESP.
REQ-015 RESP: drive ack[winner]=1 for exactly this cycle; clear gnt; go to IDLE.
REQ-016 Latency: req[i] first sampled high at edge k (with i winning) -> gnt[i] high after edge k, out updated after edge k+1, ack[i] high after edge k+2; throughput is one operation per 3 cycles.
REQ-017 Arithmetic SHALL be modulo 2^16; carry out is discarded, with no overflow indication.
REQ-018 Arbitration SHALL follow REQ-026 (macro-selected policy).
REQ-019 Operands SHALL be captured only in IDLE; a/b changes after capture have no effect on the result.
REQ-020 Dropping req[i] after grant SHALL NOT abort; ack[i] and out are still produced.
REQ-021 A requester holding req high through its ack cycle SHALL be treated as a new request at the following IDLE evaluation.
REQ-022 req bits arriving in ADD or RESP SHALL be ignored until IDLE; no requests are queued internally.
REQ-023 At most one bit of gnt and one bit of ack SHALL be high in any cycle.

Reset
REQ-024 While rst_n=0: FSM=IDLE, gnt=0, ack=0, out=16'h0000, busy=0, operand registers=0, round-robin pointer=0; all take effect immediately without a clock.
REQ-025 Reset asserted mid-operation SHALL abandon it with no ack; the first arbitration after release uses pointer 0.

Configuration
REQ-026 Macro ADD16_ARB_RR_EN: when defined, the policy is round-robin — search starts at the pointer index, the first requesting index upward (mod N_REQ) wins, and the pointer moves to winner+1 mod N_REQ at capture; when undefined, the policy is fixed priority with index 0 highest, and no pointer register exists.

Verification
REQ-027 Single request: req=4'b0001, a0=16'h1234, b0=16'h0001 -> gnt=0001 at k+1, ack=0001 at k+3 with out=16'h1235, busy high for 3 cycles.
REQ-028 Wrap: req=4'b0100, a2=16'hFFFF, b2=16'h0002 -> ack[2] pulse, out=16'h0001.
REQ-029 Contention with RR enabled: req=4'b1111 held -> ack order 0,1,2,3,0, one ack every 3 cycles; with RR disabled -> ack[0] every 3 cycles and never ack[1..3].
REQ-030 Abandon/ignore: req[1] dropped the cycle after gnt[1] -> ack[1] still pulses with the captured sum; req[3] raised only during ADD and dropped before IDLE -> never granted.
REQ-031 Reset mid-op: rst_n low during ADD -> gnt, ack and out reset to 0 immediately, no ack issued; after release, req=4'b1010 (RR enabled) -> requester 1 granted first.
